// File: rtl/decimator.sv
// Keep-one-in-R decimator placed after the FIR filter. R is loaded over the shared message bus.
// Optional DECIMATE_SUM_EN replaces pick-first with per-half integrate-and-dump over each R-sample group.
`ifndef MSG_WIDTH
`define MSG_WIDTH 32
`endif

module decimator #(
  parameter int WIDTH         = 32,
  parameter int MWIDTH        = 1,
  parameter int MAX_DECIM     = 16,
  parameter int DEFAULT_DECIM = 1,
  parameter int DECIM_ID      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_nd,
  input  logic [MWIDTH-1:0]     in_m,
  input  logic [`MSG_WIDTH-1:0] in_msg,
  input  logic                  in_msg_nd,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_nd,
  output logic [MWIDTH-1:0]     out_m,
  output logic [`MSG_WIDTH-1:0] out_msg,
  output logic                  out_msg_nd,
  output logic                  error
);
  localparam int MW = `MSG_WIDTH;
  localparam int RW = $clog2(MAX_DECIM + 1);
  localparam int HW = WIDTH / 2;
  localparam logic [MW-2:0] MAXV = (MW-1)'(MAX_DECIM);

  typedef enum logic {IDLE, WAIT_VAL} state_t;
  state_t state, state_nxt;

  logic          is_hdr, own_hdr, val_ok;
  logic [MW-2:0] val;
  logic          fwd, load_r, set_err;
  logic [RW-1:0] r, cnt;
  logic          last, emit;
  logic [WIDTH-1:0] data_nxt;

  assign is_hdr  = in_msg[MW-1];
  assign own_hdr = is_hdr && (in_msg[MW-2:MW-9] == 8'(DECIM_ID));
  assign val     = in_msg[MW-2:0];
  assign val_ok  = (val != '0) && (val <= MAXV);

  // A header seen while waiting for a value is flagged, then treated as fresh.
  always_comb begin
    state_nxt = state;
    fwd       = 1'b0;
    load_r    = 1'b0;
    set_err   = 1'b0;
    if (in_msg_nd) begin
      if (state == WAIT_VAL && !is_hdr) begin
        state_nxt = IDLE;
        if (val_ok) load_r  = 1'b1;
        else        set_err = 1'b1;
      end else begin
        if (state == WAIT_VAL) set_err = 1'b1;
        if (own_hdr) state_nxt = WAIT_VAL;
        else begin
          state_nxt = IDLE;
          fwd       = 1'b1;
        end
      end
    end
  end

  assign last = (cnt == r - RW'(1));

`ifdef DECIMATE_SUM_EN
  logic [HW-1:0] acc_re, acc_im, sum_re, sum_im;
  assign sum_re   = acc_re + in_data[WIDTH-1:HW];
  assign sum_im   = acc_im + in_data[HW-1:0];
  assign emit     = in_nd && last;
  assign data_nxt = {sum_re, sum_im};

  // Dump on the group's last sample; an R load also restarts the group.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (load_r || (in_nd && last)) begin
      acc_re <= '0;
      acc_im <= '0;
    end else if (in_nd) begin
      acc_re <= sum_re;
      acc_im <= sum_im;
    end
  end
`else
  assign emit     = in_nd && (cnt == '0);
  assign data_nxt = in_data;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      r          <= RW'(DEFAULT_DECIM);
      cnt        <= '0;
      out_data   <= '0;
      out_nd     <= 1'b0;
      out_m      <= '0;
      out_msg    <= '0;
      out_msg_nd <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_nxt;
      out_msg_nd <= fwd;
      out_nd     <= emit;
      if (set_err) error <= 1'b1;
      if (fwd) out_msg <= in_msg;
      if (emit) begin
        out_data <= data_nxt;
        out_m    <= in_m;
      end
      if (in_nd) cnt <= last ? '0 : cnt + RW'(1);
      // A concurrent sample already used the old R/counter; the load wins here.
      if (load_r) begin
        r   <= val[RW-1:0];
        cnt <= '0;
      end
    end
  end
endmodule
